// File: rtl/imem_boot_loader.sv
// Byte-stream image loader: length header, LE words into imem, then core_en.
// Define CHECKSUM_EN to require a trailing XOR checksum byte before DONE.
module imem_boot_loader #(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_en,
  output logic              load_busy,
  output logic              load_err,
  output logic [ADDR_W:0]   words_loaded
);

`ifdef CHECKSUM_EN
  typedef enum logic [2:0] {
    S_HDR0,
    S_HDR1,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;
`else
  typedef enum logic [2:0] {
    S_HDR0,
    S_HDR1,
    S_DATA,
    S_DONE,
    S_ERR
  } state_t;
`endif

  state_t            r_state;
  state_t            w_next;
  logic [15:0]       r_count;
  logic [1:0]        r_bidx;
  logic [23:0]       r_asm;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [ADDR_W:0]   r_wl;
`ifdef CHECKSUM_EN
  logic [7:0]        r_xor;
`endif

  logic              w_busy;
  logic              w_acc;
  logic [15:0]       w_hdr_cnt;
  logic [16:0]       w_wl_next;
  logic              w_last;
  logic              w_hdr_zero;
  logic              w_hdr_big;

  assign w_busy = (r_state == S_HDR0) ||
                  (r_state == S_HDR1) ||
`ifdef CHECKSUM_EN
                  (r_state == S_CSUM) ||
`endif
                  (r_state == S_DATA);

  assign w_acc      = rx_valid && rx_ready;
  assign w_hdr_cnt  = {rx_data, r_count[7:0]};
  assign w_hdr_zero = (w_hdr_cnt == 16'd0);
  assign w_hdr_big  = (17'(w_hdr_cnt) > 17'(MAX_WORDS));
  assign w_wl_next  = 17'(r_wl) + 17'd1;
  assign w_last     = (r_bidx == 2'd3) &&
                      (w_wl_next == {1'b0, r_count});

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_HDR0;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (1'b1)
      r_state == S_HDR0: begin
        if (w_acc) w_next = S_HDR1;
      end
      r_state == S_HDR1: begin
        if (w_acc) begin
          if (w_hdr_zero) begin
`ifdef CHECKSUM_EN
            w_next = S_CSUM;
`else
            w_next = S_DONE;
`endif
          end else if (w_hdr_big) begin
            w_next = S_ERR;
          end else begin
            w_next = S_DATA;
          end
        end
      end
      r_state == S_DATA: begin
        if (w_acc && w_last) begin
`ifdef CHECKSUM_EN
          w_next = S_CSUM;
`else
          w_next = S_DONE;
`endif
        end
      end
`ifdef CHECKSUM_EN
      r_state == S_CSUM: begin
        if (w_acc) begin
          w_next = (rx_data == r_xor) ? S_DONE : S_ERR;
        end
      end
`endif
      default: w_next = r_state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_bidx  <= '0;
      r_asm   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wl    <= '0;
`ifdef CHECKSUM_EN
      r_xor   <= '0;
`endif
    end else begin
      r_we <= 1'b0;
      if (w_acc) begin
`ifdef CHECKSUM_EN
        r_xor <= r_xor ^ rx_data;
`endif
        unique case (1'b1)
          r_state == S_HDR0: r_count[7:0]  <= rx_data;
          r_state == S_HDR1: r_count[15:8] <= rx_data;
          r_state == S_DATA: begin
            r_bidx <= r_bidx + 2'd1;
            unique case (r_bidx)
              2'd0: r_asm[7:0]   <= rx_data;
              2'd1: r_asm[15:8]  <= rx_data;
              2'd2: r_asm[23:16] <= rx_data;
              default: begin
                // word index equals words already written
                r_we    <= 1'b1;
                r_addr  <= r_wl[ADDR_W-1:0];
                r_wdata <= {rx_data, r_asm};
                r_wl    <= r_wl + 1'b1;
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

  assign rx_ready     = !rst && w_busy;
  assign load_busy    = w_busy;
  assign load_err     = (r_state == S_ERR);
  // hold the core off through the final write pulse
  assign core_en      = (r_state == S_DONE) && !r_we;
  assign imem_we      = r_we;
  assign imem_addr    = r_addr;
  assign imem_wdata   = r_wdata;
  assign words_loaded = r_wl;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Testbench for imem_boot_loader: scoreboard of expected imem writes.
// Builds with or without CHECKSUM_EN.
module tb_imem_boot_loader;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [7:0]        rx_data = '0;
  logic              rx_valid = 1'b0;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_en;
  logic              load_busy;
  logic              load_err;
  logic [ADDR_W:0]   words_loaded;

  int checks = 0;
  int errors = 0;

  logic [39:0] exp_q[$];
  logic [7:0]  tb_xor;
  int          tb_widx;

  imem_boot_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(256)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .core_en      (core_en),
    .load_busy    (load_busy),
    .load_err     (load_err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && imem_we) begin
      logic [39:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr=%0h data=%08h, none expected",
                 imem_addr, imem_wdata);
      end else begin
        e = exp_q.pop_front();
        if ({imem_addr, imem_wdata} !== e) begin
          errors++;
          $display("FAIL write: got %0h/%08h, expected %0h/%08h",
                   imem_addr, imem_wdata, e[39:32], e[31:0]);
        end
      end
      checks++;
      if (core_en !== 1'b0) begin
        errors++;
        $display("FAIL core_en_with_we: got %b, expected 0", core_en);
      end
    end
  end

  task automatic do_reset(input bit chk);
    @(posedge clk); #1;
    rst = 1'b1;
    rx_valid = 1'b0;
    @(negedge clk);
    if (chk) begin
      checks++;
      if (rx_ready !== 1'b0) begin
        errors++;
        $display("FAIL rst_rx_ready: got %b, expected 0", rx_ready);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    tb_xor = '0;
    tb_widx = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok = 0;
    rx_data = b;
    rx_valid = 1'b1;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      if (rx_ready) begin
        @(posedge clk); #1;
        ok = 1;
      end
    end
    rx_valid = 1'b0;
    tb_xor = tb_xor ^ b;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: byte %02h not accepted, expected ready", b);
    end
  endtask

  task automatic send_hdr(input logic [15:0] cnt);
    send_byte(cnt[7:0]);
    send_byte(cnt[15:8]);
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    logic [7:0] a;
    a = tb_widx[7:0];
    exp_q.push_back({a, w});
    tb_widx++;
    for (int i = 0; i < 4; i++) begin
      send_byte(w[8*i +: 8]);
      if (gap) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic send_csum();
`ifdef CHECKSUM_EN
    send_byte(tb_xor);
`endif
  endtask

  task automatic wait_done(input string nm, input int nw);
    bit seen = 0;
    for (int n = 0; n < 30 && !seen; n++) begin
      @(negedge clk);
      if (core_en === 1'b1 && exp_q.size() == 0) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_core_en: got %b q=%0d, expected 1 q=0",
               nm, core_en, exp_q.size());
    end
    checks++;
    if (words_loaded !== 9'(nw)) begin
      errors++;
      $display("FAIL %s_words: got %0d, expected %0d", nm, words_loaded, nw);
    end
    checks++;
    if (load_err !== 1'b0 || rx_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s_done_flags: err=%b rdy=%b, expected 0 0",
               nm, load_err, rx_ready);
    end
  endtask

  task automatic test_reset();
    do_reset(1'b1);
    @(negedge clk);
    checks++;
    if ({imem_we, imem_addr, imem_wdata, core_en, load_err, words_loaded}
        !== '0) begin
      errors++;
      $display("FAIL reset_outputs: we=%b a=%0h d=%08h en=%b err=%b wl=%0d, expected all 0",
               imem_we, imem_addr, imem_wdata, core_en, load_err, words_loaded);
    end
    checks++;
    if (rx_ready !== 1'b1 || load_busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: rdy=%b busy=%b, expected 1 1",
               rx_ready, load_busy);
    end
  endtask

  task automatic test_basic();
    do_reset(1'b0);
    send_hdr(16'd2);
    send_word(32'h0000_0013, 1'b0);
    send_word(32'h0021_00B3, 1'b0);
    @(negedge clk);
    checks++;
    if (imem_we !== 1'b1 || core_en !== 1'b0) begin
      errors++;
      $display("FAIL basic_last_pulse: we=%b en=%b, expected 1 0",
               imem_we, core_en);
    end
    send_csum();
    @(negedge clk);
    checks++;
    if (core_en !== 1'b1) begin
      errors++;
      $display("FAIL basic_core_en_next: got %b, expected 1", core_en);
    end
    wait_done("basic", 2);
  endtask

  task automatic test_zero();
    do_reset(1'b0);
    send_hdr(16'd0);
    send_csum();
    wait_done("zero", 0);
  endtask

  task automatic test_oversize();
    do_reset(1'b0);
    send_hdr(16'd257);
    rx_data = 8'hAA;
    rx_valid = 1'b1;
    repeat (4) @(posedge clk);
    #1 rx_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (load_err !== 1'b1 || rx_ready !== 1'b0 || core_en !== 1'b0) begin
      errors++;
      $display("FAIL oversize: err=%b rdy=%b en=%b, expected 1 0 0",
               load_err, rx_ready, core_en);
    end
    checks++;
    if (words_loaded !== '0 || load_busy !== 1'b0) begin
      errors++;
      $display("FAIL oversize_wl: wl=%0d busy=%b, expected 0 0",
               words_loaded, load_busy);
    end
  endtask

  task automatic test_mid_reset();
    do_reset(1'b0);
    send_hdr(16'd2);
    send_word(32'h1111_2222, 1'b0);
    send_byte(8'h33);
    send_byte(8'h44);
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || words_loaded !== 9'd1) begin
      errors++;
      $display("FAIL midrst_pre: q=%0d wl=%0d, expected 0 1",
               exp_q.size(), words_loaded);
    end
    do_reset(1'b0);
    send_hdr(16'd1);
    send_word(32'hDEAD_BEEF, 1'b0);
    send_csum();
    wait_done("midrst", 1);
  endtask

  task automatic test_gaps();
    logic [31:0] w[3];
    w[0] = 32'h0050_0093;
    w[1] = 32'h00A0_0113;
    w[2] = 32'h0020_81B3;
    do_reset(1'b0);
    send_hdr(16'd3);
    for (int i = 0; i < 3; i++) send_word(w[i], 1'b1);
    send_csum();
    wait_done("gaps", 3);
  endtask

`ifdef CHECKSUM_EN
  task automatic test_checksum();
    do_reset(1'b0);
    send_hdr(16'd1);
    send_word(32'h0000_0013, 1'b0);
    send_byte(8'h12);
    wait_done("csum_ok", 1);
    do_reset(1'b0);
    send_hdr(16'd1);
    send_word(32'h0000_0013, 1'b0);
    send_byte(8'h13);
    repeat (3) @(negedge clk);
    checks++;
    if (load_err !== 1'b1 || core_en !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL csum_bad: err=%b en=%b q=%0d, expected 1 0 0",
               load_err, core_en, exp_q.size());
    end
  endtask
`endif

  initial begin
    tb_xor = '0;
    tb_widx = 0;
    test_reset();
    test_basic();
    test_zero();
    test_oversize();
    test_mid_reset();
    test_gaps();
`ifdef CHECKSUM_EN
    test_checksum();
`endif
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
